// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem port and
// the IF/ID register, handling stall, flush and execute redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_KILL  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pcF;
  logic [31:0] r_redir_pc;
  logic [31:0] r_skid;
  logic [31:0] r_instrD;
  logic [31:0] r_PCD;
  logic [31:0] r_PCPlus4D;
  logic        r_validD;
  logic [31:0] w_pcPlus4;

  assign w_pcPlus4 = r_pcF + 32'd4;

  // The request is suppressed during reset because the async reset lands in FETCH.
  assign imem_req  = !rst && (r_state != S_STALL);
  assign imem_addr = r_pcF;
  assign instrD    = r_instrD;
  assign PCD       = r_PCD;
  assign PCPlus4D  = r_PCPlus4D;
  assign validD    = r_validD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pcF      <= RESET_PC;
      r_redir_pc <= '0;
      r_skid     <= '0;
      r_instrD   <= NOP_INSTR;
      r_PCD      <= '0;
      r_PCPlus4D <= '0;
      r_validD   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (PCSrcE) begin
            r_instrD   <= NOP_INSTR;
            r_validD   <= 1'b0;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
            if (imem_ready) begin
              r_pcF <= PCTargetE;
            end else begin
              r_redir_pc <= PCTargetE;
              r_state    <= S_KILL;
            end
          end else if (flushD) begin
            r_instrD   <= NOP_INSTR;
            r_validD   <= 1'b0;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
          end else if (stallF) begin
            if (imem_ready) begin
              r_skid  <= imem_rdata;
              r_state <= S_STALL;
            end
          end else if (imem_ready) begin
            r_instrD   <= imem_rdata;
            r_validD   <= 1'b1;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
            r_pcF      <= w_pcPlus4;
          end else begin
            r_instrD   <= NOP_INSTR;
            r_validD   <= 1'b0;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
          end
        end

        S_KILL: begin
          // The stale request must still complete; only the newest target survives.
          if (PCSrcE) r_redir_pc <= PCTargetE;
          if (imem_ready) begin
            r_pcF   <= PCSrcE ? PCTargetE : r_redir_pc;
            r_state <= S_FETCH;
          end
          if (!(stallF && !flushD && !PCSrcE)) begin
            r_instrD   <= NOP_INSTR;
            r_validD   <= 1'b0;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
          end
        end

        S_STALL: begin
          if (PCSrcE) begin
            r_instrD   <= NOP_INSTR;
            r_validD   <= 1'b0;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
            r_pcF      <= PCTargetE;
            r_state    <= S_FETCH;
          end else if (flushD) begin
            r_instrD   <= NOP_INSTR;
            r_validD   <= 1'b0;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
            r_state    <= S_FETCH;
          end else if (!stallF) begin
            r_instrD   <= r_skid;
            r_validD   <= 1'b1;
            r_PCD      <= r_pcF;
            r_PCPlus4D <= w_pcPlus4;
            r_pcF      <= w_pcPlus4;
            r_state    <= S_FETCH;
          end
        end

        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus pushes expected IF/ID deliveries into a
// scoreboard queue; a monitor pops and compares each new valid instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, flushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } deliv_t;

  deliv_t exp_q[$];

  always #5 clk = ~clk;

  // Memory returns the address tagged in the top nibble.
  assign imem_rdata = imem_addr | 32'hA000_0000;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stallF    (stallF),
    .flushD    (flushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instrD    (instrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .validD    (validD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    deliv_t d;
    d.instr = pc | 32'hA000_0000;
    d.pc    = pc;
    d.pc4   = pc + 32'd4;
    exp_q.push_back(d);
  endtask

  // Monitor: a delivery is a valid IF/ID value that differs from the previous sample.
  logic        m_prev_valid = 1'b0;
  logic [31:0] m_prev_instr = '0;
  logic [31:0] m_prev_pc    = '0;

  always @(negedge clk) begin
    deliv_t d;
    if (rst) begin
      m_prev_valid = 1'b0;
    end else begin
      if (validD && (!m_prev_valid || instrD != m_prev_instr || PCD != m_prev_pc)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_delivery: got instr %h pc %h, expected none", instrD, PCD);
        end else begin
          d = exp_q.pop_front();
          chk("deliv_instr", instrD, d.instr);
          chk("deliv_pc", PCD, d.pc);
          chk("deliv_pc4", PCPlus4D, d.pc4);
        end
      end
      m_prev_valid = validD;
      m_prev_instr = instrD;
      m_prev_pc    = PCD;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stallF = 1'b0; flushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_ready = 1'b1;
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instrD, 32'h13);
    chk("rst_valid", validD, 0);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);

    // Streaming fetch, then a two-cycle memory wait at 0x4
    push(32'h0); push(32'h4);
    tick(); chk("seq_addr4", imem_addr, 32'h4);
    imem_ready = 1'b0;
    tick(); chk("wait_addr1", imem_addr, 32'h4); chk("wait_valid", validD, 0); chk("wait_nop", instrD, 32'h13);
    tick(); chk("wait_addr2", imem_addr, 32'h4);
    imem_ready = 1'b1;
    tick(); chk("wait_done_addr", imem_addr, 32'h8);

    // Stall while 0x8 completes: held in the skid buffer
    push(32'h8);
    stallF = 1'b1;
    tick(); chk("stall_req1", imem_req, 0); chk("stall_hold1", instrD, 32'hA000_0004);
    tick(); chk("stall_req2", imem_req, 0); chk("stall_hold2", instrD, 32'hA000_0004);
    tick(); chk("stall_hold3", PCD, 32'h4);
    stallF = 1'b0;
    tick(); chk("unstall_instr", instrD, 32'hA000_0008); chk("unstall_addr", imem_addr, 32'hC);
    chk("unstall_req", imem_req, 1);

    // Redirect with ready high: 0xC dropped
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick(); PCSrcE = 1'b0;
    chk("redir_addr", imem_addr, 32'h100); chk("redir_bubble", validD, 0);
    push(32'h100);
    tick(); chk("redir_pcd", PCD, 32'h100);

    // Redirect while 0x104 outstanding, second redirect inside KILL
    imem_ready = 1'b0;
    tick(); chk("kill_pre_addr", imem_addr, 32'h104);
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick(); PCSrcE = 1'b0;
    chk("kill_addr1", imem_addr, 32'h104); chk("kill_req", imem_req, 1);
    tick(); chk("kill_addr2", imem_addr, 32'h104);
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    tick(); PCSrcE = 1'b0;
    chk("kill_addr3", imem_addr, 32'h104); chk("kill_bubble", validD, 0);
    imem_ready = 1'b1;
    tick(); chk("kill_exit_addr", imem_addr, 32'h300);
    push(32'h300);
    tick(); chk("kill_pcd", PCD, 32'h300);

    // Async reset while in KILL
    imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h400;
    tick(); PCSrcE = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 0); chk("arst_addr", imem_addr, 32'h0);
    chk("arst_instr", instrD, 32'h13); chk("arst_valid", validD, 0); chk("arst_pcd", PCD, 32'h0);
    tick();
    rst = 1'b0; imem_ready = 1'b1;
    #1;
    chk("arst_rel_addr", imem_addr, 32'h0);
    push(32'h0);
    tick(); chk("arst_pcd_after", PCD, 32'h0);

    // PC wrap at 0xFFFFFFFC
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick(); PCSrcE = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    tick(); chk("wrap_next", imem_addr, 32'h0); chk("wrap_pc4", PCPlus4D, 32'h0);
    push(32'h0);
    tick(); chk("wrap_pcd", PCD, 32'h0);

    // Flush with ready high: refetch same PC
    flushD = 1'b1;
    tick(); flushD = 1'b0;
    chk("flush_addr", imem_addr, 32'h4); chk("flush_bubble", validD, 0);
    push(32'h4);
    tick(); chk("flush_refetch", PCD, 32'h4);

    imem_ready = 1'b0;
    tick(); tick();
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
